// File: rtl/direct_param_writer.sv
// direct_param_writer: byte-stream command front end for the DDS direct-mode
// parameter path. Frames are HEADER, CMD, optional 12-byte payload, CSUM.
// LOAD commits three 32-bit words with a param_wen pulse; ENABLE and DISABLE
// drive the direct_en level. Every output is a register.
module direct_param_writer #(
  parameter logic [7:0]  HEADER         = 8'hA5,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd120000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        param_wen,
  output logic [31:0] direct_fword,
  output logic [31:0] direct_pword,
  output logic [31:0] direct_amp,
  output logic        direct_en,
  output logic        frame_ok,
  output logic        err_csum,
  output logic        err_cmd,
  output logic        err_timeout
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_CMD     = 3'd1;
  localparam logic [2:0] S_PAYLOAD = 3'd2;
  localparam logic [2:0] S_CHECK   = 3'd3;
  localparam logic [2:0] S_COMMIT  = 3'd4;

  localparam logic [7:0] CMD_LOAD    = 8'h01;
  localparam logic [7:0] CMD_ENABLE  = 8'h02;
  localparam logic [7:0] CMD_DISABLE = 8'h03;

  localparam logic [3:0] LAST_PAYLOAD = 4'd11;

  // Running checksum step: CSUM is the XOR of CMD and every payload byte.
  function automatic logic [7:0] csum_step(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

  logic [2:0]  state;
  logic [3:0]  byte_cnt;
  logic [31:0] tcnt;
  logic [7:0]  csum;
  logic [7:0]  cmd;
  logic [95:0] shadow;

  logic        accept_s;
  logic        in_frame_s;
  logic        tmo_hit_s;

  // Byte handshake and the inter-byte timeout condition (a byte in the limit cycle wins).
  always_comb begin
    accept_s   = rx_valid && rx_ready;
    in_frame_s = (state == S_CMD) || (state == S_PAYLOAD) || (state == S_CHECK);
    if (in_frame_s && !accept_s && (tcnt == TIMEOUT_CYCLES - 32'd1)) begin
      tmo_hit_s = 1'b1;
    end else begin
      tmo_hit_s = 1'b0;
    end
  end

  // Frame FSM, payload assembly, output words and one-cycle status pulses.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state        <= S_IDLE;
      byte_cnt     <= 4'd0;
      tcnt         <= 32'd0;
      csum         <= 8'd0;
      cmd          <= 8'd0;
      shadow       <= 96'd0;
      rx_ready     <= 1'b0;
      param_wen    <= 1'b0;
      direct_fword <= 32'd0;
      direct_pword <= 32'd0;
      direct_amp   <= 32'd0;
      direct_en    <= 1'b0;
      frame_ok     <= 1'b0;
      err_csum     <= 1'b0;
      err_cmd      <= 1'b0;
      err_timeout  <= 1'b0;
    end else begin
      // Pulses last one cycle; the port is closed only while in COMMIT.
      param_wen   <= 1'b0;
      frame_ok    <= 1'b0;
      err_csum    <= 1'b0;
      err_cmd     <= 1'b0;
      err_timeout <= 1'b0;
      rx_ready    <= 1'b1;

      case (state)
        S_IDLE: begin
          tcnt <= 32'd0;
          if (accept_s && (rx_data == HEADER)) begin
            state <= S_CMD;
            csum  <= 8'd0;
          end
        end

        S_CMD: begin
          if (accept_s) begin
            tcnt <= 32'd0;
            case (rx_data)
              CMD_LOAD: begin
                csum     <= rx_data;
                cmd      <= rx_data;
                byte_cnt <= 4'd0;
                state    <= S_PAYLOAD;
              end
              CMD_ENABLE, CMD_DISABLE: begin
                csum  <= rx_data;
                cmd   <= rx_data;
                state <= S_CHECK;
              end
              default: begin
                err_cmd <= 1'b1;
                state   <= S_IDLE;
              end
            endcase
          end else if (tmo_hit_s) begin
            err_timeout <= 1'b1;
            tcnt        <= 32'd0;
            state       <= S_IDLE;
          end else begin
            tcnt <= tcnt + 32'd1;
          end
        end

        S_PAYLOAD: begin
          if (accept_s) begin
            tcnt   <= 32'd0;
            shadow <= {shadow[87:0], rx_data};
            csum   <= csum_step(csum, rx_data);
            if (byte_cnt == LAST_PAYLOAD) begin
              byte_cnt <= 4'd0;
              state    <= S_CHECK;
            end else begin
              byte_cnt <= byte_cnt + 4'd1;
            end
          end else if (tmo_hit_s) begin
            err_timeout <= 1'b1;
            tcnt        <= 32'd0;
            state       <= S_IDLE;
          end else begin
            tcnt <= tcnt + 32'd1;
          end
        end

        S_CHECK: begin
          if (accept_s) begin
            tcnt <= 32'd0;
            if (rx_data == csum) begin
              // Outputs change on this edge so they are visible in the COMMIT cycle.
              state    <= S_COMMIT;
              rx_ready <= 1'b0;
              frame_ok <= 1'b1;
              case (cmd)
                CMD_LOAD: begin
                  direct_fword <= shadow[95:64];
                  direct_pword <= shadow[63:32];
                  direct_amp   <= shadow[31:0];
                  param_wen    <= 1'b1;
                end
                CMD_ENABLE:  direct_en <= 1'b1;
                CMD_DISABLE: direct_en <= 1'b0;
                default:     direct_en <= direct_en;
              endcase
            end else begin
              err_csum <= 1'b1;
              state    <= S_IDLE;
            end
          end else if (tmo_hit_s) begin
            err_timeout <= 1'b1;
            tcnt        <= 32'd0;
            state       <= S_IDLE;
          end else begin
            tcnt <= tcnt + 32'd1;
          end
        end

        S_COMMIT: begin
          tcnt  <= 32'd0;
          state <= S_IDLE;
        end

        default: begin
          tcnt  <= 32'd0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_direct_param_writer.sv
// Self-checking bench for direct_param_writer: expected pulse events are queued
// as each frame is sent and compared when the DUT raises a status pulse.
module tb_direct_param_writer;

  logic        clk;
  logic        rstn;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        param_wen;
  logic [31:0] direct_fword;
  logic [31:0] direct_pword;
  logic [31:0] direct_amp;
  logic        direct_en;
  logic        frame_ok;
  logic        err_csum;
  logic        err_cmd;
  logic        err_timeout;

  direct_param_writer #(
    .HEADER(8'hA5),
    .TIMEOUT_CYCLES(32'd16)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .rx_ready(rx_ready),
    .param_wen(param_wen),
    .direct_fword(direct_fword),
    .direct_pword(direct_pword),
    .direct_amp(direct_amp),
    .direct_en(direct_en),
    .frame_ok(frame_ok),
    .err_csum(err_csum),
    .err_cmd(err_cmd),
    .err_timeout(err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Event flags: {param_wen, frame_ok, err_csum, err_cmd, err_timeout, rx_ready}
  typedef struct {
    logic [5:0]  flags;
    logic [31:0] f;
    logic [31:0] p;
    logic [31:0] a;
    logic        en;
  } ev_t;

  ev_t q[$];

  int checks = 0;
  int errors = 0;

  // Reference state of the held outputs.
  logic [31:0] m_f = 32'd0;
  logic [31:0] m_p = 32'd0;
  logic [31:0] m_a = 32'd0;
  logic        m_en = 1'b0;

  task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_ev(input logic [5:0] flags);
    ev_t e;
    e.flags = flags;
    e.f = m_f;
    e.p = m_p;
    e.a = m_a;
    e.en = m_en;
    q.push_back(e);
  endtask

  // Scoreboard: any status pulse pops one expected event and compares all outputs.
  always @(negedge clk) begin
    if (rstn && (param_wen || frame_ok || err_csum || err_cmd || err_timeout)) begin
      if (q.size() == 0) begin
        check("unexpected_pulse",
              {90'd0, param_wen, frame_ok, err_csum, err_cmd, err_timeout, rx_ready}, 96'd0);
      end else begin
        ev_t e;
        e = q.pop_front();
        check("pulse_flags",
              {90'd0, param_wen, frame_ok, err_csum, err_cmd, err_timeout, rx_ready},
              {90'd0, e.flags});
        check("words", {direct_fword, direct_pword, direct_amp}, {e.f, e.p, e.a});
        check("direct_en", {95'd0, direct_en}, {95'd0, e.en});
      end
    end
  end

  // Present one byte at a negedge and hold it until a cycle with rx_ready high passes.
  task automatic send_byte(input logic [7:0] b);
    logic taken;
    int   budget;
    rx_data  = b;
    rx_valid = 1'b1;
    taken    = 1'b0;
    budget   = 0;
    while (!taken && budget < 100) begin
      taken = rx_ready;
      @(negedge clk);
      budget++;
    end
    if (!taken) check("ready_wait", 96'd0, 96'd1);
    rx_valid = 1'b0;
  endtask

  task automatic send_load(input logic [31:0] f, input logic [31:0] p,
                           input logic [31:0] a, input logic [7:0] flip);
    logic [95:0] pl;
    logic [7:0]  cs;
    pl = {f, p, a};
    cs = 8'h01;
    for (int i = 0; i < 12; i++) cs = cs ^ pl[95 - 8*i -: 8];
    if (flip == 8'd0) begin
      m_f = f; m_p = p; m_a = a;
      push_ev(6'b110000);
    end else begin
      push_ev(6'b001001);
    end
    send_byte(8'hA5);
    send_byte(8'h01);
    for (int i = 0; i < 12; i++) send_byte(pl[95 - 8*i -: 8]);
    send_byte(cs ^ flip);
  endtask

  task automatic send_short(input logic [7:0] c, input logic [7:0] cs);
    if (cs != c) begin
      push_ev(6'b001001);
    end else begin
      m_en = (c == 8'h02);
      push_ev(6'b010000);
    end
    send_byte(8'hA5);
    send_byte(c);
    send_byte(cs);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check(tag, {direct_fword, direct_pword, direct_amp}, 96'd0);
    check(tag, {90'd0, rx_ready, param_wen, direct_en, frame_ok, err_csum, err_cmd | err_timeout},
          96'd0);
  endtask

  initial begin
    int gap;
    rstn     = 1'b0;
    rx_data  = 8'd0;
    rx_valid = 1'b0;
    idle(3);
    check_all_zero("reset_state");
    rstn = 1'b1;
    idle(2);

    // 1: LOAD frame
    send_load(32'h01234567, 32'h00001000, 32'h0000FFFF, 8'h00);
    idle(3);

    // 2: same frame with corrupted checksum, then a different payload, also corrupted
    send_load(32'h01234567, 32'h00001000, 32'h0000FFFF, 8'h01);
    send_load(32'hDEADBEEF, 32'h0BADF00D, 32'h12345678, 8'h01);
    idle(3);
    check("hold_after_csum", {direct_fword, direct_pword, direct_amp},
          {32'h01234567, 32'h00001000, 32'h0000FFFF});

    // 3: ENABLE / DISABLE
    send_short(8'h02, 8'h02);
    idle(2);
    check("en_level_high", {95'd0, direct_en}, 96'd1);
    send_short(8'h03, 8'h03);
    idle(2);
    check("en_level_low", {95'd0, direct_en}, 96'd0);

    // 4: unknown command, then a valid ENABLE
    push_ev(6'b000101);
    send_byte(8'hA5);
    send_byte(8'h07);
    send_short(8'h02, 8'h02);
    idle(2);

    // 5: timeout mid-payload (HEADER value inside payload is data), then a full LOAD
    push_ev(6'b000011);
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h11);
    send_byte(8'hA5);
    send_byte(8'h33);
    send_byte(8'h44);
    send_byte(8'h55);
    gap = 0;
    for (int i = 1; i <= 40; i++) begin
      if (gap == 0) begin
        @(negedge clk);
        if (err_timeout) gap = i;
      end
    end
    check("timeout_gap", gap, 16);
    send_load(32'hA5A5_0102, 32'h8000_0000, 32'h0000_0001, 8'h00);
    idle(2);

    // 6: garbage before ENABLE, then reset mid-payload
    send_byte(8'h00);
    send_byte(8'hFF);
    send_byte(8'h13);
    send_short(8'h02, 8'h02);
    idle(2);
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h99);
    send_byte(8'h88);
    send_byte(8'h77);
    rstn = 1'b0;
    idle(2);
    check_all_zero("reset_mid_frame");
    m_f = 32'd0; m_p = 32'd0; m_a = 32'd0; m_en = 1'b0;
    rstn = 1'b1;
    idle(30);
    send_short(8'h02, 8'h02);
    idle(3);

    check("queue_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
